mc_mem_scheduler: RTL and testbench

- Sequences the shared single-port 25-word pixel SRAM of the motion-compensation core.
- Arbitrates between two requesters:
  - the serial-pixel writer, which fills a circular 5x5 frame buffer;
  - window-read jobs, each of which fetches a 3x3 neighbourhood around a centre address for the calc stage.
- Issues one SRAM access per cycle and returns read data tagged with its window index.

---
 rtl/mc_pkg.sv | 41 ++++
 rtl/mc_win_addr_gen.sv | 70 +++++++
 rtl/mc_mem_scheduler.sv | 162 ++++++++++++++++
 tb/tb_mc_mem_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants, state/grant enums and window-offset helper for the
// motion-compensation memory scheduler.
package mc_pkg;

   localparam int ROWS     = 5;
   localparam int COLS     = 5;
   localparam int DEPTH    = ROWS * COLS;
   localparam int DW       = 8;
   localparam int AW       = 8;
   localparam int WIN_SIZE = 9;
   localparam int IDX_W    = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   typedef enum logic {
      READ,
      WRITE
   } grant_e;

   typedef struct packed {
      logic signed [1:0] row;
      logic signed [1:0] col;
   } win_off_t;

   // Row-major 3x3 position -> (row, col) offset in {-1, 0, +1}.
   function automatic win_off_t win_offset(input logic [IDX_W-1:0] idx);
      win_off_t   off;
      logic [1:0] r;
      logic [1:0] c;
      r       = 2'(idx / 4'd3);
      c       = 2'(idx % 4'd3);
      off.row = r - 2'd1;
      off.col = c - 2'd1;
      return off;
   endfunction

endpackage

// File: rtl/mc_win_addr_gen.sv
// Holds the centre and position of the active 3x3 window job, and produces
// the SRAM address of the current position plus the centre interior check.
module mc_win_addr_gen
   import mc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [AW-1:0]    center_i,
   input  logic             advance_i,
   output logic [AW-1:0]    addr_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             last_o,
   output logic             interior_o
);

   localparam logic [AW-1:0] COLS_A  = AW'(COLS);
   localparam logic [AW-1:0] ROW_MAX = AW'(ROWS - 2);
   localparam logic [AW-1:0] COL_MAX = AW'(COLS - 2);

   logic [AW-1:0]    center_q, center_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [AW-1:0]    cen_row, cen_col;
   win_off_t         off;
   logic signed [AW+1:0] row_term, col_term, sum;

   // A centre on the frame border would make the window wrap into a
   // neighbouring row or fall outside the buffer.
   always_comb begin
      cen_row    = center_i / COLS_A;
      cen_col    = center_i % COLS_A;
      interior_o = (cen_row != '0) && (cen_row <= ROW_MAX) &&
                   (cen_col != '0) && (cen_col <= COL_MAX);
   end

   always_comb begin
      off      = win_offset(idx_q);
      row_term = $signed({{AW{off.row[1]}}, off.row}) * $signed((AW+2)'(COLS));
      col_term = $signed({{AW{off.col[1]}}, off.col});
      sum      = $signed({2'b00, center_q}) + row_term + col_term;
      addr_o   = sum[AW-1:0];
   end

   assign idx_o  = idx_q;
   assign last_o = (idx_q == IDX_W'(WIN_SIZE - 1));

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
      center_d = center_q;
      idx_d    = idx_q;
      if (load_i) begin
         center_d = center_i;
         idx_d    = '0;
      end else if (advance_i) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
      if (!rst_n) begin
         center_q <= '0;
         idx_q    <= '0;
      end else begin
         center_q <= center_d;
         idx_q    <= idx_d;
      end
   end

endmodule

// File: rtl/mc_mem_scheduler.sv
// Single-port pixel SRAM scheduler: arbitrates the circular frame writer
// against 3x3 window-read jobs and returns read data tagged with its index.
module mc_mem_scheduler
   import mc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   input  logic [DW-1:0]    wr_data,
   output logic             wr_ready,
   output logic [AW-1:0]    wr_ptr,
   input  logic             win_start,
   input  logic [AW-1:0]    win_center,
   output logic             win_busy,
   output logic             win_err,
   output logic             rd_valid,
   output logic [DW-1:0]    rd_data,
   output logic [IDX_W-1:0] rd_index,
   output logic             win_done,
   output logic             sram_csb,
   output logic             sram_web,
   output logic [AW-1:0]    sram_addr,
   output logic [DW-1:0]    sram_din,
   input  logic [DW-1:0]    sram_dout
);

   state_e           state_q, state_d;
   grant_e           last_grant_q, last_grant_d;
   logic             err_q, err_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic             csb_q, csb_d;
   logic             web_q, web_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [DW-1:0]    din_q, din_d;

   // Read pipeline: stage 1 = access on the SRAM pins, stage 2 = data on sram_dout.
   logic             s1_valid_q, s1_valid_d, s2_valid_q;
   logic [IDX_W-1:0] s1_idx_q, s1_idx_d, s2_idx_q;
   logic             s1_last_q, s1_last_d, s2_last_q;

   logic             rd_req, wr_ok, wr_grant, rd_grant, job_done, gen_load;
   logic [AW-1:0]    gen_addr;
   logic [IDX_W-1:0] gen_idx;
   logic             gen_last, gen_interior;

   mc_win_addr_gen u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (gen_load),
      .center_i   (win_center),
      .advance_i  (rd_grant),
      .addr_o     (gen_addr),
      .idx_o      (gen_idx),
      .last_o     (gen_last),
      .interior_o (gen_interior)
   );

   // The writer yields to a pending read only when it won the previous
   // contested cycle, giving strict alternation under contention.
   always_comb begin
      rd_req   = (state_q == RUN);
      wr_ok    = !rd_req || (last_grant_q == READ);
      wr_grant = wr_valid && wr_ok;
      rd_grant = rd_req && !wr_grant;
      job_done = s2_valid_q && s2_last_q;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      err_d        = 1'b0;
      gen_load     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (win_start) begin
               if (gen_interior) begin
                  state_d  = RUN;
                  gen_load = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN:     if (rd_grant && gen_last) state_d = DRAIN;
         DRAIN:   if (job_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (wr_valid && rd_req) last_grant_d = wr_grant ? WRITE : READ;
   end

   always_comb begin
      csb_d      = 1'b1;
      web_d      = 1'b1;
      addr_d     = addr_q;
      din_d      = din_q;
      wr_ptr_d   = wr_ptr_q;
      s1_valid_d = rd_grant;
      s1_idx_d   = rd_grant ? gen_idx : '0;
      s1_last_d  = rd_grant && gen_last;

      if (wr_grant) begin
         csb_d    = 1'b0;
         web_d    = 1'b0;
         addr_d   = wr_ptr_q;
         din_d    = wr_data;
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end else if (rd_grant) begin
         csb_d  = 1'b0;
         addr_d = gen_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= READ;
         err_q        <= 1'b0;
         wr_ptr_q     <= '0;
         csb_q        <= 1'b1;
         web_q        <= 1'b1;
         addr_q       <= '0;
         din_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_idx_q     <= '0;
         s1_last_q    <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_idx_q     <= '0;
         s2_last_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
         wr_ptr_q     <= wr_ptr_d;
         csb_q        <= csb_d;
         web_q        <= web_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         s1_valid_q   <= s1_valid_d;
         s1_idx_q     <= s1_idx_d;
         s1_last_q    <= s1_last_d;
         s2_valid_q   <= s1_valid_q;
         s2_idx_q     <= s1_idx_q;
         s2_last_q    <= s1_last_q;
      end
   end

   assign wr_ready  = wr_ok;
   assign wr_ptr    = wr_ptr_q;
   assign win_busy  = (state_q != IDLE);
   assign win_err   = err_q;
   assign rd_valid  = s2_valid_q;
   assign rd_index  = s2_idx_q;
   assign rd_data   = s2_valid_q ? sram_dout : '0;
   assign win_done  = job_done;
   assign sram_csb  = csb_q;
   assign sram_web  = web_q;
   assign sram_addr = addr_q;
   assign sram_din  = din_q;

endmodule

// File: tb/tb_mc_mem_scheduler.sv
// Self-checking bench for mc_mem_scheduler: directed scenarios plus random
// traffic against a transaction-level model, with a behavioural SRAM.
module tb_mc_mem_scheduler;
   import mc_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_valid;
   logic [DW-1:0]    wr_data;
   logic             wr_ready;
   logic [AW-1:0]    wr_ptr;
   logic             win_start;
   logic [AW-1:0]    win_center;
   logic             win_busy, win_err, rd_valid, win_done;
   logic [DW-1:0]    rd_data;
   logic [IDX_W-1:0] rd_index;
   logic             sram_csb, sram_web;
   logic [AW-1:0]    sram_addr;
   logic [DW-1:0]    sram_din, sram_dout;

   always #5 clk = ~clk;

   mc_mem_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .wr_ptr     (wr_ptr),
      .win_start  (win_start),
      .win_center (win_center),
      .win_busy   (win_busy),
      .win_err    (win_err),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_index   (rd_index),
      .win_done   (win_done),
      .sram_csb   (sram_csb),
      .sram_web   (sram_web),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
   );

   // Behavioural synchronous SRAM: data appears the cycle after the read access.
   logic [DW-1:0] sram_mem [256];
   always @(posedge clk) begin
      if (sram_csb == 1'b0) begin
         if (sram_web == 1'b0) sram_mem[sram_addr] <= sram_din;
         else                  sram_dout <= sram_mem[sram_addr];
      end
   end

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      bit v;
      int idx;
      int data;
   } rd_ev_t;

   bit     m_ok = 1'b0;
   bit     m_busy;
   int     m_issued;
   int     m_center;
   int     m_wr_ptr;
   bit     m_last_read;
   bit     m_err;
   int     e_csb, e_web, e_addr, e_din;
   rd_ev_t p1, p2;
   int     m_mem [256];
   int     cyc = 0;

   function automatic bit interior(input int c);
      return (c / COLS >= 1) && (c / COLS <= ROWS - 2) &&
             (c % COLS >= 1) && (c % COLS <= COLS - 2);
   endfunction

   always @(posedge clk) begin : model_b
      bit     reading, ready, wg, rg, was_busy, finishing;
      int     k, a;
      rd_ev_t nw;
      cyc++;
      if (rst_n === 1'b0) begin
         m_ok        = 1'b1;
         m_busy      = 1'b0;
         m_issued    = 0;
         m_center    = 0;
         m_wr_ptr    = 0;
         m_last_read = 1'b1;
         m_err       = 1'b0;
         e_csb = 1; e_web = 1; e_addr = 0; e_din = 0;
         p1 = '{v:0, idx:0, data:0};
         p2 = '{v:0, idx:0, data:0};
      end else if (m_ok) begin
         was_busy  = m_busy;
         reading   = m_busy && (m_issued < WIN_SIZE);
         ready     = !reading || m_last_read;
         wg        = wr_valid && ready;
         rg        = reading && !wg;
         finishing = p2.v && (p2.idx == WIN_SIZE - 1);
         if (wr_valid && reading) m_last_read = !wg;
         nw = '{v:0, idx:0, data:0};
         if (wg) begin
            e_csb = 0; e_web = 0; e_addr = m_wr_ptr; e_din = int'(wr_data);
            m_mem[m_wr_ptr] = int'(wr_data);
            m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
         end else if (rg) begin
            k = m_issued;
            a = m_center + (k / 3 - 1) * COLS + (k % 3 - 1);
            e_csb = 0; e_web = 1; e_addr = a;
            nw = '{v:1, idx:k, data:m_mem[a]};
            m_issued++;
         end else begin
            e_csb = 1; e_web = 1;
         end
         p2 = p1;
         p1 = nw;
         if (finishing) m_busy = 1'b0;
         m_err = 1'b0;
         if (!was_busy && win_start) begin
            if (interior(int'(win_center))) begin
               m_busy   = 1'b1;
               m_issued = 0;
               m_center = int'(win_center);
            end else begin
               m_err = 1'b1;
            end
         end
      end
   end

   // Compare every output against the model once per cycle, away from the edge.
   always @(negedge clk) begin
      if (m_ok) begin
         check("wr_ready",  wr_ready,  !(m_busy && m_issued < WIN_SIZE) || m_last_read);
         check("wr_ptr",    wr_ptr,    m_wr_ptr);
         check("win_busy",  win_busy,  m_busy);
         check("win_err",   win_err,   m_err);
         check("rd_valid",  rd_valid,  p2.v);
         check("rd_index",  rd_index,  p2.idx);
         check("rd_data",   rd_data,   p2.v ? p2.data : 0);
         check("win_done",  win_done,  p2.v && p2.idx == WIN_SIZE - 1);
         check("sram_csb",  sram_csb,  e_csb);
         check("sram_web",  sram_web,  e_web);
         check("sram_addr", sram_addr, e_addr);
         check("sram_din",  sram_din,  e_din);
      end
   end

   // ---------------- event monitor for directed scenarios ----------------
   bit acc_web  [$];
   int acc_addr [$];
   int rdq_data [$];
   int rdq_idx  [$];
   int done_cnt, done_cyc, done_idx, err_cnt;
   bit busy_seen;

   always @(negedge clk) begin
      if (sram_csb === 1'b0) begin
         acc_web.push_back(sram_web);
         acc_addr.push_back(int'(sram_addr));
      end
      if (rd_valid === 1'b1) begin
         rdq_data.push_back(int'(rd_data));
         rdq_idx.push_back(int'(rd_index));
      end
      if (win_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         done_idx = int'(rd_index);
      end
      if (win_err === 1'b1) err_cnt++;
      if (win_busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic clear_mon();
      acc_web.delete();
      acc_addr.delete();
      rdq_data.delete();
      rdq_idx.delete();
      done_cnt  = 0;
      err_cnt   = 0;
      busy_seen = 1'b0;
   endtask

   function automatic int n_reads();
      int n = 0;
      foreach (acc_web[i]) if (acc_web[i]) n++;
      return n;
   endfunction

   task automatic wait_done(input string tag, input int max);
      int start;
      start = done_cnt;
      for (int i = 0; i < max && done_cnt == start; i++) tick();
      check({tag, "_done_seen"}, done_cnt - start, 1);
   endtask

   task automatic start_job(input int center);
      win_center = AW'(center);
      win_start  = 1'b1;
      tick();
      win_start  = 1'b0;
   endtask

   // Window around centre 12 after the 0x10.. fill: literal addresses and data.
   task automatic check_window(input string tag);
      int ra [$];
      int exp_a [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
      int exp_d [9] = '{'h16, 'h17, 'h18, 'h1B, 'h1C, 'h1D, 'h20, 'h21, 'h22};
      foreach (acc_web[i]) if (acc_web[i]) ra.push_back(acc_addr[i]);
      check({tag, "_nreads"}, ra.size(), 9);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("%s_addr%0d", tag, i), (i < ra.size()) ? ra[i] : -1, exp_a[i]);
         check($sformatf("%s_data%0d", tag, i), (i < rdq_data.size()) ? rdq_data[i] : -1, exp_d[i]);
         check($sformatf("%s_idx%0d", tag, i), (i < rdq_idx.size()) ? rdq_idx[i] : -1, i);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, nvec=%0d nerr=%0d", nvec, nerr);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, pos9, nrd;
      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = '0;
         m_mem[i]    = 0;
      end
      sram_dout  = '0;
      rst_n      = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = '0;
      win_start  = 1'b0;
      win_center = '0;
      clear_mon();
      tick();
      tick();

      // Reset values.
      check("rst_csb", sram_csb, 1);
      check("rst_web", sram_web, 1);
      check("rst_addr", sram_addr, 0);
      check("rst_din", sram_din, 0);
      check("rst_wr_ptr", wr_ptr, 0);
      check("rst_busy", win_busy, 0);
      check("rst_err", win_err, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_index", rd_index, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_done", win_done, 0);
      rst_n = 1'b1;
      tick();

      // Fill the frame buffer 0x10..0x28, then a 26th write wraps to address 0.
      clear_mon();
      for (int i = 0; i < 26; i++) begin
         wr_valid = 1'b1;
         wr_data  = DW'(8'h10 + i);
         check("fill_wr_ready", wr_ready, 1);
         if (i == 25) check("fill_wr_ptr_wrap", wr_ptr, 0);
         tick();
      end
      wr_valid = 1'b0;
      tick();
      check("fill_nacc", acc_addr.size(), 26);
      for (int i = 0; i < 26; i++) begin
         check($sformatf("fill_addr%0d", i), (i < acc_addr.size()) ? acc_addr[i] : -1, i % 25);
         check($sformatf("fill_web%0d", i), (i < acc_web.size()) ? acc_web[i] : 1, 0);
      end

      // Uncontended job around centre 12.
      clear_mon();
      s = cyc;
      start_job(12);
      wait_done("job12", 40);
      check_window("job12");
      check("job12_latency", done_cyc - s, 11);
      check("job12_done_idx", done_idx, 8);

      // Same job with the writer continuously requesting.
      clear_mon();
      start_job(12);
      wr_valid = 1'b1;
      for (int i = 0; i < 60 && done_cnt == 0; i++) begin
         wr_data = DW'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      tick();
      check("cont_done", done_cnt, 1);
      check("cont_first_is_write", (acc_web.size() > 0) ? acc_web[0] : 1, 0);
      pos9 = -1;
      nrd  = 0;
      foreach (acc_web[i]) begin
         if (acc_web[i]) begin
            nrd++;
            if (nrd == 9) pos9 = i;
         end
      end
      check("cont_ninth_read_slot", pos9, 17);
      check_window("cont");

      // Border centres are rejected.
      for (int j = 0; j < 2; j++) begin
         clear_mon();
         start_job((j == 0) ? 4 : 20);
         repeat (5) tick();
         check($sformatf("bad%0d_err_pulses", j), err_cnt, 1);
         check($sformatf("bad%0d_reads", j), n_reads(), 0);
         check($sformatf("bad%0d_busy", j), busy_seen, 0);
      end

      // Reset while the job is issuing index 4.
      clear_mon();
      start_job(12);
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_csb", sram_csb, 1);
      check("midrst_busy", win_busy, 0);
      check("midrst_rd_valid", rd_valid, 0);
      check("midrst_wr_ptr", wr_ptr, 0);
      repeat (15) tick();
      check("midrst_no_done", done_cnt, 0);
      clear_mon();
      start_job(12);
      wait_done("postrst", 40);
      check("postrst_nvalid", rdq_idx.size(), 9);

      // win_start repeated while busy is ignored.
      clear_mon();
      start_job(12);
      repeat (3) tick();
      start_job(7);
      repeat (4) tick();
      start_job(18);
      repeat (25) tick();
      check("rebusy_nvalid", rdq_idx.size(), 9);
      check("rebusy_ndone", done_cnt, 1);

      // Random traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         rst_n      = ($urandom_range(0, 199) != 0);
         wr_valid   = ($urandom_range(0, 1) == 1);
         wr_data    = DW'($urandom);
         win_start  = ($urandom_range(0, 7) == 0);
         win_center = AW'($urandom_range(0, 30));
         tick();
      end
      rst_n     = 1'b1;
      wr_valid  = 1'b0;
      win_start = 1'b0;
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
